// File: rtl/pc_next_sequencer.sv
`default_nettype none
// pc_next_sequencer: next-PC / fetch sequencer driving the PC register D and ClockEnable.
// Optional misaligned-redirect trap is built when PC_TRAP_VEC_EN is defined.
module pc_next_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       INC       = 4,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(4)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] pc_q,
  output logic [ADDR_W-1:0] pc_d,
  output logic              pc_we,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              instr_valid,
  output logic              trap_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);

  state_t            state;
  logic              br_pend;
  logic [ADDR_W-1:0] br_tgt_q;

  logic              have_redir;
  logic              advance;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] nxt;

  // A live redirect always beats the held one.
  assign have_redir = br_valid | br_pend;
  assign redir_tgt  = br_valid ? br_target : br_tgt_q;
  assign seq_pc     = pc_q + INC_V;

  always_comb begin
    advance = 1'b0;
    case (state)
      BOOT:    advance = 1'b1;
      FETCH:   advance = imem_ack & ~stall;
      HOLD:    advance = ~stall;
      default: advance = 1'b0;
    endcase
  end

  assign pc_we       = Tick & ~Reset & advance;
  assign imem_req    = (state == FETCH);
  assign instr_valid = imem_ack & (state == FETCH) & ~br_pend & ~br_valid;

`ifdef PC_TRAP_VEC_EN
  logic misaligned;

  assign misaligned = have_redir & (|(redir_tgt & LOW_MASK));
  assign nxt        = have_redir ? redir_tgt : seq_pc;
  assign pc_d       = (state == BOOT) ? RESET_VEC : (misaligned ? TRAP_VEC : nxt);
  assign trap_o     = pc_we & misaligned & (state != BOOT);
`else
  assign nxt    = have_redir ? (redir_tgt & ~LOW_MASK) : seq_pc;
  assign pc_d   = (state == BOOT) ? RESET_VEC : nxt;
  assign trap_o = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= BOOT;
      br_pend  <= 1'b0;
      br_tgt_q <= '0;
    end else if (Tick) begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ack && !stall) begin
            br_pend <= 1'b0;
          end else begin
            // The stalled word is already squashed if a redirect arrived with it.
            if (imem_ack) state <= HOLD;
            if (br_valid) begin
              br_pend  <= 1'b1;
              br_tgt_q <= br_target;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            br_pend <= 1'b0;
            state   <= FETCH;
          end else if (br_valid) begin
            br_pend  <= 1'b1;
            br_tgt_q <= br_target;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_next_sequencer.sv
`default_nettype none
// tb_pc_next_sequencer: directed vector table, reset corner case, and randomized run
// against a transaction-level model of the fetch sequencer.
module tb_pc_next_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0004;
  localparam int unsigned INC       = 4;
  localparam logic [31:0] PC_POR    = 32'hDEAD_BEE0;
`ifdef PC_TRAP_VEC_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Tick = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_we;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        trap_o;

  int total = 0;
  int bad = 0;

  pc_next_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Tick        (Tick),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .pc_q        (pc_q),
    .pc_d        (pc_d),
    .pc_we       (pc_we),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .trap_o      (trap_o)
  );

  always #5 Clock = ~Clock;

  // The PC register the sequencer sits in front of.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) pc_q <= PC_POR;
    else if (pc_we) pc_q <= pc_d;
  end

  typedef struct {
    logic        tick;
    logic        stall;
    logic        bv;
    logic [31:0] bt;
    logic        ack;
    logic        we;
    logic [31:0] d;
    logic        req;
    logic        iv;
    logic        trap;
    logic [31:0] pcq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic tick, input logic stl, input logic bv,
                              input logic [31:0] bt, input logic ack, input logic we,
                              input logic [31:0] d, input logic req, input logic iv,
                              input logic trap, input logic [31:0] pcq);
    vec_t v;
    v.tick = tick; v.stall = stl; v.bv = bv; v.bt = bt; v.ack = ack;
    v.we = we; v.d = d; v.req = req; v.iv = iv; v.trap = trap; v.pcq = pcq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic tick, input logic stl, input logic bv,
                       input logic [31:0] bt, input logic ack);
    Tick = tick; stall = stl; br_valid = bv; br_target = bt; imem_ack = ack;
  endtask

  // Model state: boot pending, word held by a stall, and the redirects queued while busy.
  logic        m_booted;
  logic        m_held;
  logic [31:0] m_pend[$];

  task automatic model_step();
    logic        have, fetching, adv, etrap, eiv;
    logic [31:0] tgt, ed;
    have     = br_valid || (m_pend.size() > 0);
    tgt      = br_valid ? br_target : ((m_pend.size() > 0) ? m_pend[$] : 32'h0);
    fetching = m_booted && !m_held;
    adv      = Tick && (!m_booted || (fetching && imem_ack && !stall) || (m_held && !stall));
    etrap    = 1'b0;
    if (!m_booted) ed = RESET_VEC;
    else if (have && (tgt % INC) != 0) begin
      if (TRAP_EN) begin
        ed = TRAP_VEC;
        etrap = adv;
      end else begin
        ed = tgt - (tgt % INC);
      end
    end else if (have) ed = tgt;
    else ed = pc_q + INC;
    eiv = fetching && imem_ack && (m_pend.size() == 0) && !br_valid;

    check("rnd_we", {31'b0, pc_we}, {31'b0, adv});
    check("rnd_req", {31'b0, imem_req}, {31'b0, fetching});
    check("rnd_iv", {31'b0, instr_valid}, {31'b0, eiv});
    check("rnd_trap", {31'b0, trap_o}, {31'b0, etrap});
    if (adv) check("rnd_pc_d", pc_d, ed);

    if (Tick) begin
      if (!m_booted) m_booted = 1'b1;
      else if (adv) begin
        m_pend.delete();
        m_held = 1'b0;
      end else begin
        if (fetching && imem_ack) m_held = 1'b1;
        if (br_valid) m_pend.push_back(br_target);
      end
    end
  endtask

  initial begin
    logic [31:0] tpc;
    logic [31:0] bt;
    tpc = TRAP_EN ? 32'h4 : 32'h100;

    //             tick stl bv  bt            ack we  d                     req iv  trap     pcq
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h0,                0, 0, 0,       PC_POR));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'h4,                1, 1, 0,       32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'h8,                1, 1, 0,       32'h4));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'hC,                1, 0, 0,       32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'hC,                1, 0, 0,       32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'hC,                1, 0, 0,       32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'hC,                1, 1, 0,       32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'h10,               1, 1, 0,       32'hC));
    tbl.push_back(mk(1, 0, 1, 32'h100,      0, 0, 32'h100,              1, 0, 0,       32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h100,              1, 0, 0,       32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'h100,              1, 0, 0,       32'h10));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'h104,              1, 1, 0,       32'h100));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0, 32'h108,              1, 1, 0,       32'h104));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h108,              0, 0, 0,       32'h104));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 0, 32'h108,              0, 0, 0,       32'h104));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h108,              0, 0, 0,       32'h104));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h108,              0, 0, 0,       32'h104));
    tbl.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC,       1, 0, 0,       32'h108));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 32'h0,                1, 1, 0,       32'hFFFF_FFFC));
    tbl.push_back(mk(1, 0, 1, 32'h102,      1, 1, tpc,                  1, 0, TRAP_EN, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, tpc + 32'h4,          1, 0, 0,       tpc));

    repeat (2) @(negedge Clock);
    check("reset_we", {31'b0, pc_we}, 32'h0);
    check("reset_req", {31'b0, imem_req}, 32'h0);
    check("reset_iv", {31'b0, instr_valid}, 32'h0);
    check("reset_trap", {31'b0, trap_o}, 32'h0);
    check("reset_pc_d", pc_d, RESET_VEC);
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clock);
      drive(tbl[i].tick, tbl[i].stall, tbl[i].bv, tbl[i].bt, tbl[i].ack);
      #2;
      check($sformatf("v%0d_pc_q", i), pc_q, tbl[i].pcq);
      check($sformatf("v%0d_we", i), {31'b0, pc_we}, {31'b0, tbl[i].we});
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      check($sformatf("v%0d_iv", i), {31'b0, instr_valid}, {31'b0, tbl[i].iv});
      check($sformatf("v%0d_trap", i), {31'b0, trap_o}, {31'b0, tbl[i].trap});
      if (tbl[i].we) check($sformatf("v%0d_pc_d", i), pc_d, tbl[i].d);
    end

    // Reset lands mid-fetch; a late ack during boot must be ignored.
    @(negedge Clock);
    drive(1, 0, 0, 32'h0, 0);
    #2;
    check("mid_req_before", {31'b0, imem_req}, 32'h1);
    Reset = 1'b1;
    #1;
    check("mid_req_drop", {31'b0, imem_req}, 32'h0);
    check("mid_we", {31'b0, pc_we}, 32'h0);
    imem_ack = 1'b1;
    #1;
    check("mid_late_ack_iv", {31'b0, instr_valid}, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    #2;
    check("boot_we", {31'b0, pc_we}, 32'h1);
    check("boot_pc_d", pc_d, RESET_VEC);
    check("boot_req", {31'b0, imem_req}, 32'h0);
    check("boot_iv", {31'b0, instr_valid}, 32'h0);
    @(negedge Clock);
    drive(1, 0, 0, 32'h0, 0);
    #2;
    check("boot_pc_q", pc_q, RESET_VEC);
    check("boot_then_req", {31'b0, imem_req}, 32'h1);

    // Randomized run from a fresh reset.
    @(negedge Clock);
    drive(0, 0, 0, 32'h0, 0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    m_booted = 1'b0;
    m_held = 1'b0;
    m_pend.delete();
    for (int n = 0; n < 2000; n++) begin
      @(negedge Clock);
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 6) == 0), bt, ($urandom_range(0, 1) == 1));
      #2;
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
